hdmi_capture_sequencer: RTL and testbench
=========================================

Name: hdmi_capture_sequencer

Overview:
- Sequences the HDMI ingester: gates its enable so only whole, frame-aligned active video reaches the pixel FIFO.
- Locks to the vsync rising edge and counts active pixels and lines against the configured geometry.
- Aborts a frame on FIFO overflow or geometry error, then resynchronises at the next vsync.
- Sits in the HDMI pixel-clock domain, between the HDMI receiver sync outputs and the ingester's i_hdmiEnable.

Parameters:
- H_ACTIVE, 800, active pixels per line
- V_ACTIVE, 480, active lines per frame
- PIX_W, 12, pixel counter width (must hold H_ACTIVE+1)
- LINE_W, 11, line counter width (must hold V_ACTIVE)

Ports:
- i_clock  in  1  HDMI pixel clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_captureEnable  in  1  level; request continuous frame capture
- i_hdmiVsync  in  1  receiver vsync, active-high
- i_hdmiDe  in  1  receiver data-enable (active video)
- i_fifoFull  in  1  pixel FIFO full flag
- i_clearErrors  in  1  one-cycle pulse; clears sticky flags
- o_hdmiEnable  out  1  to ingester i_hdmiEnable
- o_frameActive  out  1  high while a frame is being captured
- o_frameDone  out  1  one-cycle pulse after last pixel of a complete frame
- o_overflow  out  1  sticky; FIFO was full during a forwarded pixel
- o_geometryError  out  1  sticky; line length or line count mismatch
- o_lineCount  out  LINE_W  completed lines in current frame

Behaviour:
- Reset (async, immediate, including mid-frame): state IDLE; all outputs 0; counters 0; vsync/DE edge registers 0.
- o_hdmiEnable = i_hdmiDe AND r_gate. This is combinational, zero latency, so it aligns with the pixel the ingester samples.
  - r_gate is registered. It is 1 only in ARMED and LINE, and only while r_pixCount < H_ACTIVE.
- Edge detection: r_vsyncD/r_deD are registered copies.
  - vsyncRise = i_hdmiVsync & !r_vsyncD.
  - deFall = !i_hdmiDe & r_deD.
- States:
  - IDLE: gate 0. Go to WAIT_VSYNC when i_captureEnable=1.
  - WAIT_VSYNC: gate 0. On vsyncRise, go to ARMED; clear line and pixel counters.
  - ARMED (between lines): gate 1. When i_hdmiDe=1, go to LINE. That pixel is forwarded and r_pixCount becomes 1.
  - LINE: r_pixCount increments on each cycle with i_hdmiDe=1, saturating at H_ACTIVE+1. Pixels beyond H_ACTIVE are not forwarded. On deFall:
    - if r_pixCount != H_ACTIVE, set o_geometryError and go to DROP;
    - otherwise increment o_lineCount and clear r_pixCount;
    - if o_lineCount reaches V_ACTIVE, pulse o_frameDone next cycle, then go to WAIT_VSYNC if i_captureEnable=1, else IDLE;
    - otherwise go to ARMED.
  - DROP: gate 0. Wait for vsyncRise, then behave as WAIT_VSYNC's vsyncRise transition (go directly to ARMED).
- Overflow: if i_fifoFull=1 in any cycle where o_hdmiEnable=1, set o_overflow and go to DROP next cycle. The pixel in that cycle is lost by the ingester.
- vsyncRise while in ARMED or LINE (premature frame end): set o_geometryError, clear counters, stay in/enter ARMED (new frame starts).
- i_captureEnable deasserted mid-frame: the current frame completes; the block then goes to IDLE. Deassertion in WAIT_VSYNC or DROP returns to IDLE immediately.
- o_frameActive = state is ARMED or LINE.
- i_clearErrors clears o_overflow and o_geometryError. If a set event occurs in the same cycle, set wins.
- o_frameDone never pulses for an aborted frame.

Decomposition:
- Shared include file: state encodings (IDLE, WAIT_VSYNC, ARMED, LINE, DROP) and default HDMI geometry constants, shared with the LCD timing generator.
- One sub-module, sync_edge_detect: single-bit registered edge detector with rise/fall outputs. Instantiated for vsync and DE.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=3, capture enabled, vsync pulse, then 3 lines of 4 DE cycles separated by 2 blank cycles. Required: o_hdmiEnable high for exactly 12 cycles, coincident with DE; o_frameDone one pulse 1 cycle after the last deFall; o_lineCount=3; no flags set.
- DE asserted before the first vsync. Required: o_hdmiEnable stays 0 until after vsyncRise; first forwarded pixel is the first DE cycle after vsync.
- Line with 6 DE cycles. Required: only 4 forwarded; o_geometryError=1 at deFall; gate 0 until next vsync; no o_frameDone.
- i_fifoFull=1 on the 2nd pixel of line 2. Required: o_overflow=1; o_hdmiEnable 0 from the next cycle until the next frame's first DE; next frame completes with o_frameDone.
- Vsync after line 1 of 3. Required: o_geometryError=1; o_lineCount reset to 0; a following full frame yields o_frameDone.
- i_reset asserted mid-line. Required: o_hdmiEnable falls in the same cycle (async); all outputs 0; recapture waits for vsync.

Source files
------------

// File: rtl/hdmi_capture_sequencer_pkg.sv
// Shared definitions for the HDMI capture sequencer: state encoding and the
// default HDMI active-video geometry, also used by the LCD timing generator.
package hdmi_capture_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VSYNC,
        ARMED,
        LINE,
        DROP
    } seqState_t;

    localparam int unsigned HDMI_H_ACTIVE = 800;
    localparam int unsigned HDMI_V_ACTIVE = 480;

    function automatic logic isCapturing(input seqState_t state);
        return (state == ARMED) || (state == LINE);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Single-bit registered edge detector; reports rising and falling edges of a
// signal that is already synchronous to the clock.
module sync_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_signal,
    output logic o_rise,
    output logic o_fall
);

    logic r_signalD;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_signalD <= 1'b0;
        end else begin
            r_signalD <= i_signal;
        end
    end

    assign o_rise = i_signal & ~r_signalD;
    assign o_fall = ~i_signal & r_signalD;

endmodule

// File: rtl/hdmi_capture_sequencer.sv
// Gates the HDMI ingester enable so only whole, vsync-aligned frames of the
// configured geometry reach the pixel FIFO; aborts and resyncs on errors.
module hdmi_capture_sequencer
    import hdmi_capture_sequencer_pkg::*;
#(
    parameter int unsigned H_ACTIVE = HDMI_H_ACTIVE,
    parameter int unsigned V_ACTIVE = HDMI_V_ACTIVE,
    parameter int unsigned PIX_W    = 12,
    parameter int unsigned LINE_W   = 11
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_captureEnable,
    input  logic              i_hdmiVsync,
    input  logic              i_hdmiDe,
    input  logic              i_fifoFull,
    input  logic              i_clearErrors,
    output logic              o_hdmiEnable,
    output logic              o_frameActive,
    output logic              o_frameDone,
    output logic              o_overflow,
    output logic              o_geometryError,
    output logic [LINE_W-1:0] o_lineCount
);

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(H_ACTIVE);
    localparam logic [PIX_W-1:0]  PIX_SAT   = PIX_W'(H_ACTIVE + 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(V_ACTIVE);

    seqState_t         r_state, stateNext;
    logic [PIX_W-1:0]  r_pixCount, pixCountNext;
    logic [LINE_W-1:0] r_lineCount, lineCountNext;
    logic              r_gate, gateNext;
    logic              r_frameDone, frameDoneNext;
    logic              r_overflow, overflowNext;
    logic              r_geometryError, geometryErrorNext;
    logic              setOverflow, setGeometryError;
    logic              vsyncRise, deFall, overflowEvent;
    logic              unusedVsyncFall, unusedDeRise;

    sync_edge_detect u_vsyncEdge (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_signal (i_hdmiVsync),
        .o_rise   (vsyncRise),
        .o_fall   (unusedVsyncFall)
    );

    sync_edge_detect u_deEdge (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_signal (i_hdmiDe),
        .o_rise   (unusedDeRise),
        .o_fall   (deFall)
    );

    // Combinational so the enable lines up with the pixel the ingester samples.
    assign o_hdmiEnable  = i_hdmiDe & r_gate;
    assign overflowEvent = o_hdmiEnable & i_fifoFull;

    always_comb begin
        stateNext        = r_state;
        pixCountNext     = r_pixCount;
        lineCountNext    = r_lineCount;
        frameDoneNext    = 1'b0;
        setOverflow      = 1'b0;
        setGeometryError = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (i_captureEnable) begin
                    stateNext = WAIT_VSYNC;
                end
            end
            WAIT_VSYNC, DROP: begin
                if (!i_captureEnable) begin
                    stateNext = IDLE;
                end else if (vsyncRise) begin
                    stateNext     = ARMED;
                    pixCountNext  = '0;
                    lineCountNext = '0;
                end
            end
            ARMED, LINE: begin
                if (vsyncRise) begin
                    // Frame ended early: flag it and treat this vsync as a new frame.
                    setGeometryError = 1'b1;
                    stateNext        = ARMED;
                    pixCountNext     = '0;
                    lineCountNext    = '0;
                end else if (overflowEvent) begin
                    setOverflow = 1'b1;
                    stateNext   = DROP;
                end else if (r_state == ARMED) begin
                    if (i_hdmiDe) begin
                        stateNext    = LINE;
                        pixCountNext = PIX_W'(1);
                    end
                end else if (deFall) begin
                    if (r_pixCount != PIX_LAST) begin
                        setGeometryError = 1'b1;
                        stateNext        = DROP;
                    end else begin
                        lineCountNext = r_lineCount + 1'b1;
                        pixCountNext  = '0;
                        if (lineCountNext == LINE_LAST) begin
                            frameDoneNext = 1'b1;
                            stateNext     = i_captureEnable ? WAIT_VSYNC : IDLE;
                        end else begin
                            stateNext = ARMED;
                        end
                    end
                end else if (i_hdmiDe && (r_pixCount != PIX_SAT)) begin
                    pixCountNext = r_pixCount + 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        gateNext          = isCapturing(stateNext) && (pixCountNext < PIX_LAST);
        // A set event in the same cycle as a clear pulse wins.
        overflowNext      = setOverflow | (r_overflow & ~i_clearErrors);
        geometryErrorNext = setGeometryError | (r_geometryError & ~i_clearErrors);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_pixCount      <= '0;
            r_lineCount     <= '0;
            r_gate          <= 1'b0;
            r_frameDone     <= 1'b0;
            r_overflow      <= 1'b0;
            r_geometryError <= 1'b0;
        end else begin
            r_state         <= stateNext;
            r_pixCount      <= pixCountNext;
            r_lineCount     <= lineCountNext;
            r_gate          <= gateNext;
            r_frameDone     <= frameDoneNext;
            r_overflow      <= overflowNext;
            r_geometryError <= geometryErrorNext;
        end
    end

    assign o_frameActive   = isCapturing(r_state);
    assign o_frameDone     = r_frameDone;
    assign o_overflow      = r_overflow;
    assign o_geometryError = r_geometryError;
    assign o_lineCount     = r_lineCount;

endmodule

// File: tb/tb_hdmi_capture_sequencer.sv
// Scoreboard bench for hdmi_capture_sequencer: a frame-level model predicts
// which DE cycles are forwarded and when frames complete.
module tb_hdmi_capture_sequencer;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int LW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          capEn = 1'b0;
    logic          vsync = 1'b0;
    logic          de = 1'b0;
    logic          fifoFull = 1'b0;
    logic          clearErr = 1'b0;
    logic          hdmiEnable, frameActive, frameDone, overflow, geomErr;
    logic [LW-1:0] lineCount;

    int nChecks = 0;
    int nFails = 0;
    int stepNo = 0;
    int curTag = -1;
    int enCount = 0;
    int expTags[$];
    int expDone[$];
    bit modelPrevOpen = 0;
    int frameNo = 0;
    int lens[V];
    int fulls[V];

    always #5 clock = ~clock;

    hdmi_capture_sequencer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .PIX_W    (4),
        .LINE_W   (LW)
    ) dut (
        .i_clock         (clock),
        .i_reset         (reset),
        .i_captureEnable (capEn),
        .i_hdmiVsync     (vsync),
        .i_hdmiDe        (de),
        .i_fifoFull      (fifoFull),
        .i_clearErrors   (clearErr),
        .o_hdmiEnable    (hdmiEnable),
        .o_frameActive   (frameActive),
        .o_frameDone     (frameDone),
        .o_overflow      (overflow),
        .o_geometryError (geomErr),
        .o_lineCount     (lineCount)
    );

    task automatic check(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFails++;
            $display("FAIL %s: got %0d, expected %0d (step %0d)", name, actual, expected, stepNo);
        end
    endtask

    task automatic step(input bit v, input bit d, input bit f, input bit c, input int tag);
        @(posedge clock);
        #1;
        vsync    = v;
        de       = d;
        fifoFull = f;
        clearErr = c;
        curTag   = tag;
        stepNo++;
    endtask

    // Monitor: every forwarded pixel and every frameDone pulse must match the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            if (hdmiEnable) begin
                enCount++;
                if (expTags.size() == 0) check("forward_unexpected", curTag, -1);
                else check("forward_tag", curTag, expTags.pop_front());
            end
            if (frameDone) begin
                if (expDone.size() == 0) check("frameDone_unexpected", stepNo, -1);
                else check("frameDone_step", stepNo, expDone.pop_front());
            end
        end
    end

    // One frame: vsync, nLines lines of lens[] DE cycles, fifoFull on pixel fulls[].
    task automatic runFrame(input int nLines, input bit captured, input bit dropCap,
                            input bit noClear);
        bit alive;
        bit expOvf;
        bit expGeom;
        int done;
        int tag;
        bit f;
        alive   = captured;
        expOvf  = 0;
        expGeom = captured && modelPrevOpen;
        done    = 0;
        frameNo++;
        repeat ($urandom_range(2, 4)) step(0, 0, 0, 0, -1);
        repeat ($urandom_range(1, 2)) step(1, 0, 0, 0, -1);
        repeat ($urandom_range(1, 3)) step(0, 0, 0, 0, -1);
        for (int l = 0; l < nLines; l++) begin
            for (int p = 0; p < lens[l]; p++) begin
                tag = frameNo * 4096 + l * 64 + p;
                f   = (p == fulls[l]);
                if (alive && p < H) begin
                    expTags.push_back(tag);
                    if (f) begin
                        expOvf = 1;
                        alive  = 0;
                    end
                end
                step(0, 1, f, 0, tag);
                if (dropCap && l == 0 && p == 0) capEn = 1'b0;
            end
            if (alive) begin
                if (lens[l] != H) begin
                    expGeom = 1;
                    alive   = 0;
                end else begin
                    done++;
                    if (done == V) begin
                        expDone.push_back(stepNo + 2);
                        alive = 0;
                    end
                end
            end
            repeat ($urandom_range(1, 3)) step(0, 0, 0, 0, -1);
        end
        step(0, 0, 0, 0, -1);
        check("overflow", overflow, expOvf);
        check("geometryError", geomErr, expGeom);
        check("frameActive", frameActive, alive);
        if (captured) check("lineCount", lineCount, done);
        modelPrevOpen = alive;
        if (!noClear) step(0, 0, 0, 1, -1);
    endtask

    task automatic setLines(input int a, input int b, input int c,
                            input int fa, input int fb, input int fc);
        lens[0]  = a;
        lens[1]  = b;
        lens[2]  = c;
        fulls[0] = fa;
        fulls[1] = fb;
        fulls[2] = fc;
    endtask

    initial begin
        int enBefore;
        int nl;
        repeat (3) step(0, 0, 0, 0, -1);
        check("reset_enable", hdmiEnable, 0);
        check("reset_frameActive", frameActive, 0);
        check("reset_frameDone", frameDone, 0);
        check("reset_lineCount", lineCount, 0);
        reset = 1'b0;
        capEn = 1'b1;

        // DE before any vsync must not be forwarded.
        for (int i = 0; i < 8; i++) step(0, i[0], 0, 0, 900 + i);
        check("pre_vsync_enable_count", enCount, 0);

        // Clean frame: exactly V*H forwarded cycles.
        setLines(H, H, H, -1, -1, -1);
        enBefore = enCount;
        runFrame(V, 1, 0, 0);
        check("clean_frame_enable_count", enCount - enBefore, V * H);

        setLines(H, H + 2, H, -1, -1, -1);
        runFrame(V, 1, 0, 0);
        setLines(H, H, H, -1, 1, -1);
        runFrame(V, 1, 0, 0);
        setLines(H, H, H, -1, -1, -1);
        runFrame(V, 1, 0, 0);
        runFrame(1, 1, 0, 0);
        runFrame(V, 1, 0, 0);

        // Capture dropped mid-frame: frame completes, the next one is ignored.
        runFrame(V, 1, 1, 0);
        runFrame(V, 0, 0, 0);
        capEn = 1'b1;

        for (int fr = 0; fr < 30; fr++) begin
            nl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, V - 1)) : V;
            for (int l = 0; l < V; l++) begin
                lens[l]  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, H + 2)) : H;
                fulls[l] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, lens[l] - 1)) : -1;
            end
            runFrame(nl, 1, 0, 0);
        end

        // Leave a sticky error set, then reset asynchronously in the middle of a line.
        setLines(H + 1, H, H, -1, -1, -1);
        runFrame(V, 1, 0, 1);
        check("sticky_before_reset", geomErr, 1);
        step(0, 0, 0, 0, -1);
        step(1, 0, 0, 0, -1);
        step(0, 0, 0, 0, -1);
        expTags.push_back(70000);
        step(0, 1, 0, 0, 70000);
        expTags.push_back(70001);
        step(0, 1, 0, 0, 70001);
        step(0, 1, 0, 0, 70002);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_enable", hdmiEnable, 0);
        check("async_reset_frameActive", frameActive, 0);
        check("async_reset_overflow", overflow, 0);
        check("async_reset_geometryError", geomErr, 0);
        check("async_reset_lineCount", lineCount, 0);
        step(0, 0, 0, 0, -1);
        step(0, 0, 0, 0, -1);
        reset = 1'b0;
        modelPrevOpen = 0;
        enBefore = enCount;
        for (int i = 0; i < 10; i++) step(0, (i % 3) != 0, 0, 0, 800 + i);
        check("post_reset_no_forward", enCount - enBefore, 0);
        setLines(H, H, H, -1, -1, -1);
        runFrame(V, 1, 0, 0);

        repeat (4) step(0, 0, 0, 0, -1);
        check("tags_left", expTags.size(), 0);
        check("frameDone_left", expDone.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
